// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// S_TRAP exists only when MCU_ILLEGAL_TRAP_EN is defined.
package mcu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL
`ifdef MCU_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_ITYPE: imm_sel = IMM_I;
            OP_STORE:          imm_sel = IMM_S;
            OP_BRANCH:         imm_sel = IMM_B;
            OP_JAL:            imm_sel = IMM_J;
            default:           imm_sel = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mcu_alu_dec.sv
// ALU decoder: ALUOp plus instruction fields to ALU control code,
// zero-extended to ALUCTRL_W bits.
module mcu_alu_dec
    import mcu_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  aluop_t               alu_op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 op5,
    output logic [ALUCTRL_W-1:0] alu_control
);

    logic [2:0] code;

    always_comb begin
        code = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // only R-type (op5=1) can select SUB; addi ignores bit 30
                    3'b000:  code = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  code = ALU_SLT;
                    3'b110:  code = ALU_OR;
                    3'b111:  code = ALU_AND;
                    default: code = ALU_ADD;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign alu_control = ALUCTRL_W'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I controller FSM with memory ready handshake and BEQ/BNE.
// Define MCU_ILLEGAL_TRAP_EN to park illegal instructions in a sticky trap state.
//
// state      | meaning
// S_FETCH    | read instruction at PC, PC+4 -> PC when mem_ready
// S_DECODE   | compute branch/jump target OldPC+imm
// S_MEMADR   | rs1+imm effective address
// S_MEMREAD  | load access, wait mem_ready
// S_MEMWB    | write load data to rd
// S_MEMWRITE | store access, wait mem_ready
// S_EXECR    | rs1 op rs2
// S_EXECI    | rs1 op imm
// S_ALUWB    | write ALUOut to rd
// S_BRANCH   | compare rs1-rs2, load target on taken
// S_JAL      | PC <- target, ALU computes OldPC+4 for rd
// S_TRAP     | illegal instruction seen, held until reset
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int ALUCTRL_W   = 3,
    parameter int SUPPORT_BNE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           imm_src,
    output logic                 reg_write,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 illegal
);

    localparam logic BNE_EN = (SUPPORT_BNE != 0);

    state_t state, state_nxt, decode_nxt;
    aluop_t alu_op;
    logic   decode_ok;
    logic   pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        decode_nxt = S_FETCH;
        decode_ok  = 1'b1;
        case (opcode)
            OP_LOAD, OP_STORE: decode_nxt = S_MEMADR;
            OP_RTYPE:          decode_nxt = S_EXECR;
            OP_ITYPE:          decode_nxt = S_EXECI;
            OP_JAL:            decode_nxt = S_JAL;
            OP_BRANCH: begin
                if (funct3 == 3'b000 || (BNE_EN && funct3 == 3'b001))
                    decode_nxt = S_BRANCH;
                else
                    decode_ok = 1'b0;
            end
            default: decode_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        pc_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        adr_src       = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALURESULT;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
                if (mem_ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                if (decode_ok)
                    state_nxt = decode_nxt;
                else
`ifdef MCU_ILLEGAL_TRAP_EN
                    state_nxt = S_TRAP;
`else
                    state_nxt = S_FETCH;
`endif
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_nxt = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                result_src    = RES_DATA;
                reg_write_raw = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                if (mem_ready) state_nxt = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = SRCA_RS1;
                alu_op       = ALUOP_SUB;
                // funct3[0] inverts the sense for BNE
                pc_write_raw = zero ^ (BNE_EN & funct3[0]);
                state_nxt    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                pc_write_raw = 1'b1;
                state_nxt    = S_ALUWB;
            end
`ifdef MCU_ILLEGAL_TRAP_EN
            S_TRAP: state_nxt = S_TRAP;
`endif
            default: state_nxt = S_FETCH;
        endcase
    end

    // strobes are forced low while reset is held, independent of mem_ready
    assign pc_write  = pc_write_raw & rst_n;
    assign mem_write = mem_write_raw & rst_n;
    assign ir_write  = ir_write_raw & rst_n;
    assign reg_write = reg_write_raw & rst_n;
    assign imm_src   = imm_sel(opcode);

`ifdef MCU_ILLEGAL_TRAP_EN
    assign illegal = rst_n & (state == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

    mcu_alu_dec #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (opcode[5]),
        .alu_control (alu_control)
    );

endmodule
